// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   UART_FRAME_BITS = 10;
  localparam logic UART_START_LVL  = 1'b0;
  localparam logic UART_STOP_LVL   = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with registered occupancy count; head byte is visible on pop_data.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_unit.sv
// Buffered 8N1 serial transmitter: FIFO front end, framing FSM, sticky drop flag.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          err_clr,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop_err
);

  localparam int                TW         = $clog2(CLK_DIV);
  localparam logic [TW-1:0]     TIMER_LOAD = TW'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_state_t   state;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          timer_done;
  logic          pop;
  logic          drop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_ready   = !fifo_full;
  assign drop       = tx_valid && fifo_full;
  assign timer_done = (bit_timer == '0);
  assign busy       = (state != IDLE) || !fifo_empty;

  // Pop condition must mirror the IDLE/STOP branches of the FSM below.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)                    pop = 1'b1;
      else if (state == STOP && timer_done) pop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx_out    <= UART_STOP_LVL;
      bit_timer <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= START;
            shreg     <= fifo_head;
            bit_timer <= TIMER_LOAD;
            tx_out    <= UART_START_LVL;
          end
        end
        START: begin
          if (timer_done) begin
            state     <= DATA;
            bit_timer <= TIMER_LOAD;
            bit_idx   <= '0;
            tx_out    <= shreg[0];
            shreg     <= shreg >> 1;
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        DATA: begin
          if (timer_done) begin
            bit_timer <= TIMER_LOAD;
            if (bit_idx == LAST_BIT) begin
              state  <= STOP;
              tx_out <= UART_STOP_LVL;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        STOP: begin
          if (timer_done) begin
            if (!fifo_empty) begin
              state     <= START;
              shreg     <= fifo_head;
              bit_timer <= TIMER_LOAD;
              tx_out    <= UART_START_LVL;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A dropped push wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        drop_err <= 1'b0;
    else if (drop)    drop_err <= 1'b1;
    else if (err_clr) drop_err <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Self-checking bench for uart_tx_unit against a frame-timing reference model.
module tb_uart_tx_unit;

  localparam int CD    = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       err_clr;
  logic       tx_out;
  logic       busy;
  logic [3:0] fifo_count;
  logic       drop_err;

  int checks = 0;
  int errors = 0;

  uart_tx_unit #(
    .CLK_DIV    (CD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .err_clr    (err_clr),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_count (fifo_count),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus the edge index at which the current frame began.
  logic [7:0] q[$];
  bit         m_active;
  logic [7:0] m_cur;
  int         m_start;
  int         m_cyc;
  bit         m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_cur    = '0;
    m_start  = 0;
    m_cyc    = 0;
    m_drop   = 1'b0;
  endtask

  function automatic logic exp_line();
    int k;
    if (!m_active) return 1'b1;
    k = (m_cyc - m_start) / CD;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic check_all();
    check("tx_out",     {31'd0, tx_out},     {31'd0, exp_line()});
    check("fifo_count", {28'd0, fifo_count}, q.size());
    check("tx_ready",   {31'd0, tx_ready},   {31'd0, q.size() != DEPTH});
    check("busy",       {31'd0, busy},       {31'd0, m_active || q.size() != 0});
    check("drop_err",   {31'd0, drop_err},   {31'd0, m_drop});
  endtask

  // One clock edge: decide model actions from pre-edge state, then compare after the edge.
  task automatic step();
    bit         ending, do_pop, do_push, do_drop, clr;
    logic [7:0] pb;
    int         sz;
    sz      = q.size();
    ending  = m_active && (m_cyc - m_start == 10 * CD);
    do_pop  = (!m_active || ending) && sz != 0;
    do_push = tx_valid && sz < DEPTH;
    do_drop = tx_valid && sz >= DEPTH;
    clr     = err_clr;
    pb      = tx_data;
    @(posedge clk);
    #1;
    if (ending) m_active = 1'b0;
    if (do_pop) begin
      m_cur    = q.pop_front();
      m_active = 1'b1;
      m_start  = m_cyc;
    end
    if (do_push) q.push_back(pb);
    if (do_drop) m_drop = 1'b1;
    else if (clr) m_drop = 1'b0;
    check_all();
    m_cyc++;
  endtask

  task automatic idle_steps(input int n);
    tx_valid = 1'b0;
    err_clr  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset    = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    err_clr  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Single byte 0xA5 from idle.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    idle_steps(50);

    // Eight back-to-back bytes.
    for (int i = 0; i < 8; i++) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      step();
    end
    idle_steps(330);

    // Overfill: ten pushes, the last one dropped.
    for (int i = 0; i < 10; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    check("drop_after_overfill", {31'd0, drop_err}, 32'd1);

    // Clear alone, then clear coinciding with another dropped push.
    err_clr = 1'b1;
    step();
    check("drop_cleared", {31'd0, drop_err}, 32'd0);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    step();
    check("drop_set_wins", {31'd0, drop_err}, 32'd1);
    idle_steps(400);

    // Reset asserted during data bit 3 with a second byte queued.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_data  = 8'h81;
    step();
    idle_steps(16);
    #2;
    reset = 1'b1;
    #1;
    check("async_tx_out", {31'd0, tx_out}, 32'd1);
    check("async_count",  {28'd0, fifo_count}, 32'd0);
    check("async_busy",   {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle_steps(100);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 1200; i++) begin
      tx_data  = 8'($urandom);
      tx_valid = ($urandom_range(7) == 0);
      err_clr  = ($urandom_range(15) == 0);
      step();
    end
    idle_steps(420);
    check("final_idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
